adc_capture_buffer: RTL and testbench

//  Pre/post-trigger sample capture stage that consumes the 8-bit ADC sample stream from the ADC interface.

---
 rtl/adc_capture_buffer.sv | 363 ++++++++++++++++++++++++++++++++++++
 tb/tb_adc_capture_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_buffer.sv
// -----------------------------------------------------------------------------
// adc_capture_buffer
//
// Pre/post-trigger capture stage for the 8-bit ADC sample stream. Samples are
// written into a DEPTH-entry circular RAM while armed. Once enough pre-trigger
// history is buffered, a level crossing (or a software force) starts the
// post-trigger count. After P further samples the buffer freezes and software
// drains it oldest-first through an 8-bit Avalon-MM slave.
//
// Optional feature macro: ADC_CAP_DECIM_EN
//   When defined, register 7 (DECIM) keeps only every (DECIM+1)th valid
//   sample for storage, trigger detection and counting.
//
// Ports
//   main_clk      single rising-edge clock
//   rst           synchronous active-high reset
//   sample_data   ADC sample, qualified by sample_valid
//   sample_valid  one sample per cycle when high
//   address       Avalon-MM word address (4 bits)
//   read, write   Avalon-MM strobes
//   writedata     Avalon-MM write data
//   readdata      Avalon-MM read data, fixed 1-cycle latency, 0 when idle
//   irq           high while the capture is complete (DONE)
//   capturing     high in ARMED, WAIT_TRIG or POST
//
// Register map
//   0 CTRL    W: b0 arm, b1 force_trig, b2 abort (pulses)
//   1 STAT    R: b[2:0] state, b3 done, b4 rd_empty
//   2 THR     trigger threshold
//   3 MODE    b0: 0 rising, 1 falling
//   4 POST_LO post-trigger count [7:0]
//   5 POST_HI post-trigger count [ADDR_W-1:8]
//   6 DATA    R: pops the next buffered sample (DONE only)
//   7 DECIM   decimation factor (only with ADC_CAP_DECIM_EN)
// -----------------------------------------------------------------------------
module adc_capture_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              main_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic [3:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              irq,
  output logic              capturing
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Level-crossing detector; prev is the previous effective sample.
  function automatic logic is_crossing(
    input logic [DATA_W-1:0] prev,
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] thr,
    input logic              falling
  );
    logic hit;
    if (falling) begin
      hit = (prev >= thr) && (cur < thr);
    end else begin
      hit = (prev < thr) && (cur >= thr);
    end
    return hit;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   fill_r;
  logic [ADDR_W-1:0] post_cnt_r;
  logic [ADDR_W:0]   rd_cnt_r;
  logic [DATA_W-1:0] prev_r;
  logic              prev_valid_r;
  logic              force_lat_r;

  logic [DATA_W-1:0] thr_r;
  logic              mode_r;
  logic [ADDR_W-1:0] post_r;

  logic [7:0]        readdata_r;
  logic              irq_r;
  logic              capturing_r;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic              ctrl_wr_s;
  logic              arm_s;
  logic              force_s;
  logic              abort_s;
  logic              in_capture_s;
  logic              sample_take_s;
  logic              eff_valid_s;
  logic              wr_en_s;
  logic              rd_empty_s;
  logic              pop_s;
  logic [ADDR_W:0]   pre_target_s;
  logic [ADDR_W:0]   fill_nxt_s;
  logic              crossing_s;
  logic              post_last_s;
  state_t            trig_dest_s;
  logic              done_entry_s;
  logic [15:0]       post_ext_s;

  assign ctrl_wr_s    = write && (address == 4'd0);
  assign arm_s        = ctrl_wr_s && writedata[0];
  assign force_s      = ctrl_wr_s && writedata[1];
  assign abort_s      = ctrl_wr_s && writedata[2];
  assign in_capture_s = (state_r == ST_ARMED) || (state_r == ST_WAIT_TRIG) ||
                        (state_r == ST_POST);

  // A sample in the same cycle as arm/abort belongs to neither capture.
  assign eff_valid_s  = sample_valid && in_capture_s && sample_take_s;
  assign wr_en_s      = eff_valid_s && !arm_s && !abort_s;

  assign rd_empty_s   = (rd_cnt_r == (ADDR_W+1)'(DEPTH));
  assign pop_s        = read && (address == 4'd6) && (state_r == ST_DONE) && !rd_empty_s;

  // post_r is ADDR_W bits wide, so it can never exceed DEPTH-1 and
  // min(post, DEPTH-1) is simply post_r.
  assign pre_target_s = (ADDR_W+1)'(DEPTH - 1) - {1'b0, post_r};
  assign fill_nxt_s   = fill_r + {{ADDR_W{1'b0}}, wr_en_s};
  assign crossing_s   = wr_en_s && prev_valid_r &&
                        is_crossing(prev_r, sample_data, thr_r, mode_r);
  assign post_last_s  = (post_cnt_r + ADDR_W'(1)) == post_r;
  assign trig_dest_s  = (post_r == {ADDR_W{1'b0}}) ? ST_DONE : ST_POST;
  assign done_entry_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
  assign post_ext_s   = {{(16-ADDR_W){1'b0}}, post_r};

`ifdef ADC_CAP_DECIM_EN
  logic [7:0] decim_r;
  logic [7:0] decim_cnt_r;

  assign sample_take_s = (decim_cnt_r == decim_r);

  // Decimation phase counter: restarts on arm, advances per raw valid sample.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      decim_cnt_r <= 8'd0;
    end else if (arm_s || abort_s) begin
      decim_cnt_r <= 8'd0;
    end else if (sample_valid && in_capture_s) begin
      decim_cnt_r <= sample_take_s ? 8'd0 : (decim_cnt_r + 8'd1);
    end else begin
      decim_cnt_r <= decim_cnt_r;
    end
  end
`else
  assign sample_take_s = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks arm, arm restarts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else if (arm_s) begin
      state_nxt_s = ST_ARMED;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_ARMED: begin
          // A force seen while pre-filling fires as soon as pre-fill completes,
          // so WAIT_TRIG is skipped entirely.
          if (fill_nxt_s >= pre_target_s) begin
            state_nxt_s = (force_lat_r || force_s) ? trig_dest_s : ST_WAIT_TRIG;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_WAIT_TRIG: begin
          if (force_s || crossing_s) begin
            state_nxt_s = trig_dest_s;
          end else begin
            state_nxt_s = ST_WAIT_TRIG;
          end
        end
        ST_POST: begin
          if (wr_en_s && post_last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_POST;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_DONE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Software-visible configuration registers.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      thr_r   <= {DATA_W{1'b0}};
      mode_r  <= 1'b0;
      post_r  <= {ADDR_W{1'b0}};
`ifdef ADC_CAP_DECIM_EN
      decim_r <= 8'd0;
`endif
    end else if (write) begin
      case (address)
        4'd2: thr_r              <= writedata[DATA_W-1:0];
        4'd3: mode_r             <= writedata[0];
        4'd4: post_r[7:0]        <= writedata;
        4'd5: post_r[ADDR_W-1:8] <= writedata[ADDR_W-9:0];
`ifdef ADC_CAP_DECIM_EN
        4'd7: decim_r            <= writedata;
`endif
        default: thr_r           <= thr_r;
      endcase
    end else begin
      thr_r <= thr_r;
    end
  end

  // Sample RAM write port; contents are not reset.
  always_ff @(posedge main_clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= sample_data;
    end
  end

  // Capture pointers, fill/post counters, previous sample and force latch.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      wr_ptr_r     <= {ADDR_W{1'b0}};
      fill_r       <= {(ADDR_W+1){1'b0}};
      post_cnt_r   <= {ADDR_W{1'b0}};
      prev_r       <= {DATA_W{1'b0}};
      prev_valid_r <= 1'b0;
      force_lat_r  <= 1'b0;
    end else if (abort_s) begin
      force_lat_r  <= 1'b0;
    end else if (arm_s) begin
      wr_ptr_r     <= {ADDR_W{1'b0}};
      fill_r       <= {(ADDR_W+1){1'b0}};
      post_cnt_r   <= {ADDR_W{1'b0}};
      prev_valid_r <= 1'b0;
      force_lat_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r     <= wr_ptr_r + ADDR_W'(1);
        prev_r       <= sample_data;
        prev_valid_r <= 1'b1;
      end else begin
        wr_ptr_r     <= wr_ptr_r;
      end
      if (state_r == ST_ARMED) begin
        fill_r <= fill_nxt_s;
      end else begin
        fill_r <= fill_r;
      end
      if ((state_r == ST_POST) && wr_en_s) begin
        post_cnt_r <= post_cnt_r + ADDR_W'(1);
      end else begin
        post_cnt_r <= post_cnt_r;
      end
      // The latch only lives while pre-filling; it is consumed on leaving ARMED.
      force_lat_r <= (state_r == ST_ARMED) && (state_nxt_s == ST_ARMED) &&
                     (force_lat_r || force_s);
    end
  end

  // Readout pointer: starts at the oldest sample on DONE entry, stops after DEPTH pops.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      rd_ptr_r <= {ADDR_W{1'b0}};
      rd_cnt_r <= {(ADDR_W+1){1'b0}};
    end else if (done_entry_s) begin
      // The final sample is written in the same cycle, so take the advanced pointer.
      rd_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, wr_en_s};
      rd_cnt_r <= {(ADDR_W+1){1'b0}};
    end else if (arm_s && !abort_s) begin
      rd_cnt_r <= {(ADDR_W+1){1'b0}};
    end else if (pop_s) begin
      rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      rd_cnt_r <= rd_cnt_r + (ADDR_W+1)'(1);
    end else begin
      rd_ptr_r <= rd_ptr_r;
      rd_cnt_r <= rd_cnt_r;
    end
  end

  // Avalon read data: one-cycle latency, zero whenever no read is presented.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      readdata_r <= 8'd0;
    end else if (read) begin
      case (address)
        4'd1:    readdata_r <= {3'b000, rd_empty_s, (state_r == ST_DONE), state_r};
        4'd2:    readdata_r <= 8'(thr_r);
        4'd3:    readdata_r <= {7'b0000000, mode_r};
        4'd4:    readdata_r <= post_ext_s[7:0];
        4'd5:    readdata_r <= post_ext_s[15:8];
        4'd6:    readdata_r <= pop_s ? 8'(mem_r[rd_ptr_r]) : 8'd0;
`ifdef ADC_CAP_DECIM_EN
        4'd7:    readdata_r <= decim_r;
`endif
        default: readdata_r <= 8'd0;
      endcase
    end else begin
      readdata_r <= 8'd0;
    end
  end

  // Status outputs registered from next state so they track state_r exactly.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      irq_r       <= 1'b0;
      capturing_r <= 1'b0;
    end else begin
      irq_r       <= (state_nxt_s == ST_DONE);
      capturing_r <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_WAIT_TRIG) ||
                     (state_nxt_s == ST_POST);
    end
  end

  assign readdata  = readdata_r;
  assign irq       = irq_r;
  assign capturing = capturing_r;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_buffer
//
// Directed scoreboard bench. Stimulus tasks issue Avalon reads and push the
// hand-computed expected readdata into a queue; a separate monitor compares
// readdata one cycle after each read and checks readdata is 0 otherwise.
// -----------------------------------------------------------------------------
module tb_adc_capture_buffer;

  logic       main_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_data = 8'd0;
  logic       sample_valid = 1'b0;
  logic [3:0] address = 4'd0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [7:0] writedata = 8'd0;
  logic [7:0] readdata;
  logic       irq;
  logic       capturing;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mask_q[$];
  string      name_q[$];
  bit         mon_en = 1'b0;
  logic       mon_was_rd;

  always #5 main_clk = ~main_clk;

  adc_capture_buffer dut (
    .main_clk     (main_clk),
    .rst          (rst),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .irq          (irq),
    .capturing    (capturing)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change only just after falling edges.
  task automatic tick();
    @(negedge main_clk);
    sample_valid = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rdm(input logic [3:0] a, input logic [7:0] e, input logic [7:0] m,
                     input string name);
    address = a; read = 1'b1;
    exp_q.push_back(e); mask_q.push_back(m); name_q.push_back(name);
    tick();
    read = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string name);
    rdm(a, e, 8'hFF, name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] fall_data(input int i);
    if (i < 10)       return 8'h50;
    else if (i < 20)  return 8'h30;
    else if (i < 30)  return 8'h50;
    else if (i == 30) return 8'h3F;
    else              return 8'h20;
  endfunction

  // Monitor: compare readdata one cycle after each read, expect 0 otherwise.
  initial begin
    forever begin
      @(posedge main_clk);
      mon_was_rd = read;
      #1;
      if (mon_en) begin
        if (mon_was_rd) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow: got %h expected none", readdata);
          end else begin
            logic [7:0] e, m;
            string n;
            e = exp_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
            check(n, readdata & m, e & m);
          end
        end else begin
          check("idle_rdata", readdata, 8'h00);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset_rdata", readdata, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'd0);
    check("reset_cap", {7'd0, capturing}, 8'd0);
    mon_en = 1'b1;
    rd(4'd1, 8'h00, "reset_stat");
    rd(4'd0, 8'h00, "ctrl_read");
    rd(4'd9, 8'h00, "unmapped_read");

    // Force trigger latched during pre-fill: POST entered without WAIT_TRIG.
    wr(4'd4, 8'd10); wr(4'd5, 8'd0); wr(4'd0, 8'h01);
    rd(4'd4, 8'd10, "post_lo_rb");
    for (int k = 0; k < 1013; k++) begin
      drive(8'h55);
      if (k == 5)         wr(4'd0, 8'h02);
      else if (k == 1012) rd(4'd1, 8'h01, "force_armed_last");
      else                tick();
    end
    drive(8'h55);
    rd(4'd1, 8'h03, "force_post_direct");
    check("force_cap", {7'd0, capturing}, 8'd1);
    for (int k = 0; k < 8; k++) begin
      drive(8'h55);
      tick();
    end
    check("force_irq_early", {7'd0, irq}, 8'd0);
    drive(8'h55);
    tick();
    check("force_irq_done", {7'd0, irq}, 8'd1);
    rd(4'd1, 8'h0C, "force_done_stat");

    // Reset in the middle of POST.
    wr(4'd4, 8'hFF); wr(4'd5, 8'h03); wr(4'd0, 8'h01);
    tick();
    wr(4'd0, 8'h02);
    rd(4'd1, 8'h03, "pre_rst_post");
    do_reset();
    check("rst_irq", {7'd0, irq}, 8'd0);
    check("rst_cap", {7'd0, capturing}, 8'd0);
    check("rst_rdata", readdata, 8'h00);
    rd(4'd1, 8'h00, "rst_stat");
    rd(4'd4, 8'h00, "rst_post_lo");
    rd(4'd5, 8'h00, "rst_post_hi");

    // Rising trigger on a ramp, then full readout and boundary.
    wr(4'd2, 8'h80); wr(4'd4, 8'd100); wr(4'd5, 8'd0); wr(4'd3, 8'd0);
    rd(4'd2, 8'h80, "thr_rb");
    wr(4'd0, 8'h01);
    for (int i = 0; i < 1253; i++) begin
      drive(8'(i));
      if (i == 10)        rd(4'd6, 8'h00, "pop_before_done");
      else if (i == 1152) rd(4'd1, 8'h02, "rise_wait");
      else if (i == 1153) rd(4'd1, 8'h03, "rise_post");
      else                tick();
    end
    check("rise_irq", {7'd0, irq}, 8'd1);
    check("rise_cap", {7'd0, capturing}, 8'd0);
    rd(4'd1, 8'h0C, "rise_done_stat");
    for (int k = 0; k < 1024; k++) begin
      if (k == 923) rd(4'd6, 8'h80, "pop_trigger");
      else          rd(4'd6, 8'(229 + k), "pop_rise");
    end
    rd(4'd1, 8'h1C, "stat_empty");
    rd(4'd6, 8'h00, "pop_past_end");
    rd(4'd6, 8'h00, "pop_past_end2");
    rd(4'd1, 8'h1C, "stat_empty2");
    wr(4'd0, 8'h04);
    rdm(4'd1, 8'h00, 8'h0F, "abort_idle");
    check("abort_irq", {7'd0, irq}, 8'd0);

    // Falling mode: crossing in pre-fill is ignored.
    do_reset();
    wr(4'd2, 8'h40); wr(4'd3, 8'h01); wr(4'd4, 8'hE8); wr(4'd5, 8'h03);
    rd(4'd5, 8'h03, "post_hi_rb");
    wr(4'd0, 8'h01);
    for (int i = 0; i < 1031; i++) begin
      drive(fall_data(i));
      if (i == 20)      rd(4'd1, 8'h01, "fall_prefill");
      else if (i == 23) rd(4'd1, 8'h02, "fall_wait");
      else if (i == 30) rd(4'd1, 8'h02, "fall_wait_last");
      else if (i == 31) rd(4'd1, 8'h03, "fall_post");
      else              tick();
    end
    rd(4'd1, 8'h0C, "fall_done_stat");
    for (int k = 0; k < 1024; k++) begin
      rd(4'd6, fall_data(7 + k), (k == 23) ? "pop_fall_trig" : "pop_fall");
    end

`ifdef ADC_CAP_DECIM_EN
    // Decimation by 4: only every 4th input is stored and counted.
    do_reset();
    wr(4'd7, 8'd3);
    rd(4'd7, 8'd3, "decim_rb");
    wr(4'd4, 8'hFF); wr(4'd5, 8'h03); wr(4'd0, 8'h01);
    tick();
    wr(4'd0, 8'h02);
    for (int j = 0; j < 4092; j++) begin
      drive(8'(j));
      if (j == 4091) rd(4'd1, 8'h03, "decim_post_last");
      else           tick();
    end
    rd(4'd1, 8'h0C, "decim_done");
    for (int k = 0; k < 1024; k++) begin
      if (k == 0) rdm(4'd6, 8'h00, 8'h00, "pop_decim_stale");
      else        rd(4'd6, 8'(4 * k - 1), "pop_decim");
    end
`else
    wr(4'd7, 8'd3);
    rd(4'd7, 8'h00, "reg7_unmapped");
`endif

    for (int w = 0; w < 5 && exp_q.size() != 0; w++) tick();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: got %0d expected 0", exp_q.size());
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
